// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI SCLK/timing engine.
// Word/divider widths live here so the config struct has fixed field sizes.
package spi_pkg;

  localparam int unsigned MAX_BITS = 32;
  localparam int unsigned DIV_W    = 8;
  localparam int unsigned BITS_W   = $clog2(MAX_BITS + 1);
  localparam int unsigned EDGE_W   = BITS_W + 1;

  typedef enum logic [2:0] {IDLE, SETUP, RUN, HOLD, GAP} spi_state_e;

  typedef struct packed {
    logic              cpol;
    logic              cpha;
    logic [DIV_W-1:0]  half_div;
    logic [BITS_W-1:0] bits;
  } spi_cfg_t;

  typedef struct packed {
    logic sample;
    logic shift;
  } spi_strobe_t;

  // Clamp raw config: divider 0 -> 1, bits 0 or out of range -> MAX_BITS.
  function automatic spi_cfg_t cfg_normalize(logic cpol, logic cpha,
                                             logic [DIV_W-1:0] half_div,
                                             logic [BITS_W-1:0] bits);
    spi_cfg_t c;
    c.cpol     = cpol;
    c.cpha     = cpha;
    c.half_div = (half_div == '0) ? DIV_W'(1) : half_div;
    c.bits     = ((bits == '0) || (bits > BITS_W'(MAX_BITS))) ? BITS_W'(MAX_BITS) : bits;
    return c;
  endfunction

  // CPHA=0 samples on leading and shifts on trailing (the first bit is already out);
  // CPHA=1 shifts on leading and samples on trailing.
  function automatic spi_strobe_t mode_decode(logic cpha, logic leading, logic last);
    spi_strobe_t s;
    if (cpha) begin
      s.shift  = leading;
      s.sample = !leading;
    end else begin
      s.sample = leading;
      s.shift  = !leading && !last;
    end
    return s;
  endfunction

endpackage

// File: rtl/spi_sclk_engine_timer.sv
// Half-period tick generator: tick every half_div_i enabled cycles, restarts when disabled.
module spi_edge_timer
  import spi_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] half_div_i,
  output logic             tick_c_o
);

  logic [DIV_W-1:0] cnt_q;

  assign tick_c_o = en_i && (cnt_q == (half_div_i - DIV_W'(1)));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (!en_i || tick_c_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + DIV_W'(1);
    end
  end

endmodule

// File: rtl/spi_sclk_engine.sv
// SPI master clock/timing engine: per-transfer mode, word length, divider,
// CS setup/hold/gap sequencing and abort. All outputs are registered.
module spi_sclk_engine
  import spi_pkg::*;
#(
  parameter int unsigned CS_SETUP_CYC = 1,
  parameter int unsigned CS_HOLD_CYC  = 1,
  parameter int unsigned MIN_GAP_CYC  = 2
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_Cfg_CPOL,
  input  logic              i_Cfg_CPHA,
  input  logic [DIV_W-1:0]  i_Cfg_Half_Div,
  input  logic [BITS_W-1:0] i_Cfg_Bits,
  input  logic              i_TX_DV,
  input  logic              i_Abort,
  output logic              o_TX_Ready,
  output logic              o_Busy,
  output logic              o_CS_Active,
  output logic              o_SPI_Clk,
  output logic              o_Leading_Edge,
  output logic              o_Trailing_Edge,
  output logic              o_Sample_Strobe,
  output logic              o_Shift_Strobe,
  output logic [BITS_W-1:0] o_Bit_Idx,
  output logic              o_Done
);

  localparam int unsigned CNT_MAX    = (1 << DIV_W) + CS_SETUP_CYC + CS_HOLD_CYC + MIN_GAP_CYC;
  localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1);
  localparam int unsigned SETUP_LAST = (CS_SETUP_CYC > 0) ? CS_SETUP_CYC - 1 : 0;
  localparam int unsigned GAP_LAST   = (MIN_GAP_CYC > 0) ? MIN_GAP_CYC - 1 : 0;

  spi_state_e        state_q;
  spi_cfg_t          cfg_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [EDGE_W-1:0] edge_q;
  logic [BITS_W-1:0] bit_idx_q;
  logic ready_q, busy_q, cs_q, sclk_q, lead_q, trail_q, sample_q, shift_q, done_q;

  logic              tick_c;
  logic              timer_en_c;
  logic [EDGE_W-1:0] edge_d;
  logic              leading_c;
  logic              last_c;
  logic [CNT_W-1:0]  hold_last_c;
  spi_strobe_t       strb_c;

  assign timer_en_c  = (state_q == RUN) && !i_Abort;
  assign edge_d      = edge_q + EDGE_W'(1);
  assign leading_c   = edge_d[0];
  assign last_c      = (edge_d == {cfg_q.bits, 1'b0});
  assign hold_last_c = CNT_W'(cfg_q.half_div) + CNT_W'(CS_HOLD_CYC) - CNT_W'(1);
  assign strb_c      = mode_decode(cfg_q.cpha, leading_c, last_c);

  spi_edge_timer u_timer (
    .clk_i      (i_Clk),
    .rst_i      (i_Rst),
    .en_i       (timer_en_c),
    .half_div_i (cfg_q.half_div),
    .tick_c_o   (tick_c)
  );

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q   <= IDLE;
      cfg_q     <= '0;
      cnt_q     <= '0;
      edge_q    <= '0;
      bit_idx_q <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      cs_q      <= 1'b0;
      sclk_q    <= 1'b0;
      lead_q    <= 1'b0;
      trail_q   <= 1'b0;
      sample_q  <= 1'b0;
      shift_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      lead_q   <= 1'b0;
      trail_q  <= 1'b0;
      sample_q <= 1'b0;
      shift_q  <= 1'b0;
      done_q   <= 1'b0;
      if ((state_q != IDLE) && i_Abort) begin
        sclk_q    <= cfg_q.cpol;
        cs_q      <= 1'b0;
        bit_idx_q <= '0;
        cnt_q     <= '0;
        state_q   <= (MIN_GAP_CYC == 0) ? IDLE : GAP;
        ready_q   <= (MIN_GAP_CYC == 0);
        busy_q    <= (MIN_GAP_CYC != 0);
      end else begin
        case (state_q)
          IDLE: begin
            sclk_q <= i_Cfg_CPOL;
            if (i_TX_DV) begin
              cfg_q     <= cfg_normalize(i_Cfg_CPOL, i_Cfg_CPHA, i_Cfg_Half_Div, i_Cfg_Bits);
              ready_q   <= 1'b0;
              busy_q    <= 1'b1;
              cs_q      <= 1'b1;
              cnt_q     <= '0;
              edge_q    <= '0;
              bit_idx_q <= '0;
              state_q   <= (CS_SETUP_CYC == 0) ? RUN : SETUP;
            end
          end
          SETUP: begin
            if (cnt_q == CNT_W'(SETUP_LAST)) begin
              cnt_q   <= '0;
              state_q <= RUN;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          RUN: begin
            if (tick_c) begin
              sclk_q   <= ~sclk_q;
              lead_q   <= leading_c;
              trail_q  <= !leading_c;
              sample_q <= strb_c.sample;
              shift_q  <= strb_c.shift;
              edge_q   <= edge_d;
              if (!leading_c && !last_c) bit_idx_q <= bit_idx_q + BITS_W'(1);
              if (last_c) begin
                cnt_q   <= '0;
                state_q <= HOLD;
              end
            end
          end
          HOLD: begin
            // Final half-period plus CS hold, then drop CS together with Done.
            if (cnt_q == hold_last_c) begin
              cs_q      <= 1'b0;
              done_q    <= 1'b1;
              bit_idx_q <= '0;
              cnt_q     <= '0;
              state_q   <= (MIN_GAP_CYC == 0) ? IDLE : GAP;
              ready_q   <= (MIN_GAP_CYC == 0);
              busy_q    <= (MIN_GAP_CYC != 0);
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          GAP: begin
            if (cnt_q == CNT_W'(GAP_LAST)) begin
              cnt_q   <= '0;
              state_q <= IDLE;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign o_TX_Ready      = ready_q;
  assign o_Busy          = busy_q;
  assign o_CS_Active     = cs_q;
  assign o_SPI_Clk       = sclk_q;
  assign o_Leading_Edge  = lead_q;
  assign o_Trailing_Edge = trail_q;
  assign o_Sample_Strobe = sample_q;
  assign o_Shift_Strobe  = shift_q;
  assign o_Bit_Idx       = bit_idx_q;
  assign o_Done          = done_q;

endmodule

// File: tb/tb_spi_sclk_engine.sv
// Self-checking bench for spi_sclk_engine: every cycle of each transfer is compared
// against a timeline computed arithmetically from the transfer parameters.
module tb_spi_sclk_engine;

  localparam int S  = 1;
  localparam int CH = 1;
  localparam int G  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_cpol, cfg_cpha, tx_dv, abort;
  logic [7:0] cfg_div;
  logic [5:0] cfg_bits;
  logic       tx_ready, busy, cs, sclk, lead, trail, sample, shift, done;
  logic [5:0] bit_idx;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic       ready, busy, cs, sclk, lead, trail, sample, shift;
    logic [5:0] bit_idx;
    logic       done;
  } obs_t;

  obs_t obs;
  obs_t rst_exp;
  assign obs = {tx_ready, busy, cs, sclk, lead, trail, sample, shift, bit_idx, done};

  always #5 clk = ~clk;

  spi_sclk_engine #(.CS_SETUP_CYC(S), .CS_HOLD_CYC(CH), .MIN_GAP_CYC(G)) dut (
    .i_Clk          (clk),
    .i_Rst          (rst),
    .i_Cfg_CPOL     (cfg_cpol),
    .i_Cfg_CPHA     (cfg_cpha),
    .i_Cfg_Half_Div (cfg_div),
    .i_Cfg_Bits     (cfg_bits),
    .i_TX_DV        (tx_dv),
    .i_Abort        (abort),
    .o_TX_Ready     (tx_ready),
    .o_Busy         (busy),
    .o_CS_Active    (cs),
    .o_SPI_Clk      (sclk),
    .o_Leading_Edge (lead),
    .o_Trailing_Edge(trail),
    .o_Sample_Strobe(sample),
    .o_Shift_Strobe (shift),
    .o_Bit_Idx      (bit_idx),
    .o_Done         (done)
  );

  task automatic check(input string tag, input int t, input obs_t exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s t=%0d observed=%b expected=%b", tag, t, obs, exp);
    end
  endtask

  // Expected outputs t cycles after the accept cycle; ta>0 is the cycle abort was driven.
  function automatic obs_t model(int t, logic cpol, logic cpha, int h, int b, int ta);
    obs_t e;
    int   r, dt, m, k;
    e  = '0;
    r  = 1 + S;
    dt = r + (2 * b + 1) * h + CH;
    if (ta > 0 && t > ta) begin
      e.ready = (t >= ta + 1 + G);
      e.busy  = !e.ready;
      e.sclk  = cpol;
      return e;
    end
    m = (t >= r) ? (t - r) / h : 0;
    if (m > 2 * b) m = 2 * b;
    e.cs    = (t < dt);
    e.done  = (t == dt);
    e.ready = (t >= dt + G);
    e.busy  = !e.ready;
    e.sclk  = cpol ^ m[0];
    if (t < dt) e.bit_idx = 6'(((m / 2) < (b - 1)) ? (m / 2) : (b - 1));
    if (t > r && ((t - r) % h) == 0 && ((t - r) / h) <= 2 * b) begin
      k       = (t - r) / h;
      e.lead  = k[0];
      e.trail = !k[0];
      if (cpha) begin
        e.shift  = e.lead;
        e.sample = e.trail;
      end else begin
        e.sample = e.lead;
        e.shift  = e.trail && (k != 2 * b);
      end
    end
    return e;
  endfunction

  task automatic idle_cycles(input int n, input string tag);
    obs_t e;
    for (int i = 0; i < n; i++) begin
      cfg_cpol = 1'($urandom);
      abort    = 1'($urandom);
      tx_dv    = 1'b0;
      @(posedge clk); #1;
      e       = '0;
      e.ready = 1'b1;
      e.sclk  = cfg_cpol;
      check(tag, i, e);
    end
    abort = 1'b0;
  endtask

  // Starts at a cycle where the engine should be ready; returns at the next ready cycle.
  task automatic xfer(input logic cpol, input logic cpha, input logic [7:0] div,
                      input logic [5:0] bits, input int abort_k, input bit abort_acc,
                      input bit hold_dv, input int rst_at, input string tag);
    int h, b, ta, tend;
    h    = (div == 8'd0) ? 1 : int'(div);
    b    = (bits == 6'd0 || bits > 6'd32) ? 32 : int'(bits);
    ta   = (abort_k > 0) ? 1 + S + abort_k * h : 0;
    tend = (ta > 0) ? ta + 1 + G : 1 + S + (2 * b + 1) * h + CH + G;
    checks++;
    assert (tx_ready === 1'b1) else begin
      failures++;
      $error("FAIL %s_ready_at_start observed=%b expected=1", tag, tx_ready);
    end
    cfg_cpol = cpol;
    cfg_cpha = cpha;
    cfg_div  = div;
    cfg_bits = bits;
    tx_dv    = 1'b1;
    abort    = abort_acc;
    for (int t = 1; t <= tend; t++) begin
      @(posedge clk); #1;
      abort    = 1'b0;
      tx_dv    = hold_dv;
      cfg_cpol = 1'($urandom);
      cfg_cpha = 1'($urandom);
      cfg_div  = 8'($urandom);
      cfg_bits = 6'($urandom);
      check(tag, t, model(t, cpol, cpha, h, b, ta));
      if (t == ta) abort = 1'b1;
      if (t == rst_at) begin
        rst = 1'b1;
        #1;
        check({tag, "_async"}, t, rst_exp);
        @(posedge clk); #1;
        check({tag, "_held"}, t + 1, rst_exp);
        tx_dv = 1'b0;
        rst   = 1'b0;
        return;
      end
    end
  endtask

  initial begin
    logic       rc, rp;
    logic [7:0] rd;
    logic [5:0] rb;
    int         bb, ak;
    bit         hd;

    rst_exp       = '0;
    rst_exp.ready = 1'b1;
    rst = 1'b1; tx_dv = 1'b0; abort = 1'b0;
    cfg_cpol = 1'b1; cfg_cpha = 1'b0; cfg_div = 8'd0; cfg_bits = 6'd0;
    #1;
    check("reset", 0, rst_exp);
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", 0, rst_exp);
    rst = 1'b0;

    idle_cycles(4, "idle");
    xfer(1'b0, 1'b0, 8'd2, 6'd8, 0, 1'b0, 1'b0, 0, "mode0_d2_b8");
    xfer(1'b1, 1'b1, 8'd1, 6'd1, 0, 1'b0, 1'b0, 0, "mode3_d1_b1");
    idle_cycles(2, "idle2");
    xfer(1'($urandom), 1'b1, 8'd0, 6'd0, 0, 1'b0, 1'b0, 0, "bits0_div0");
    xfer(1'b0, 1'b0, 8'd2, 6'd8, 5, 1'b0, 1'b0, 0, "abort_edge5");
    xfer(1'b1, 1'b0, 8'd3, 6'd4, 0, 1'b1, 1'b0, 0, "abort_with_dv");
    xfer(1'b0, 1'b1, 8'd2, 6'd3, 0, 1'b0, 1'b1, 0, "b2b_a");
    xfer(1'b1, 1'b0, 8'd1, 6'd5, 0, 1'b0, 1'b1, 0, "b2b_b");
    xfer(1'b0, 1'b0, 8'd1, 6'd40, 0, 1'b0, 1'b0, 0, "b2b_c_bits40");

    for (int i = 0; i < 10; i++) begin
      rc = 1'($urandom);
      rp = 1'($urandom);
      rd = 8'($urandom_range(0, 3));
      rb = 6'($urandom_range(0, 12));
      bb = (rb == 6'd0) ? 32 : int'(rb);
      ak = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 2 * bb)) : 0;
      hd = (i < 9) ? 1'($urandom) : 1'b0;
      xfer(rc, rp, rd, rb, ak, 1'($urandom), hd, 0, "random");
    end

    idle_cycles(3, "idle3");
    xfer(1'b0, 1'b0, 8'd2, 6'd8, 0, 1'b0, 1'b1, 15, "rst_mid_run");
    idle_cycles(3, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
